dds_multich_amp: RTL

//  NUM_CH-channel DDS; one shared phase accumulator, per-channel phase offset and signed amplitude scaling.

---
 rtl/dds_multich_amp.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dds_multich_amp.sv
// dds_multich_amp: multi-channel DDS with one shared phase accumulator,
// per-channel phase offset, runtime-loadable sine LUT and signed amplitude
// scaling with round-half-up and positive saturation.
// Pipeline: S0 accumulate, S1 address, S2 LUT read, S3 multiply, S4 round/sat.
// Compile-time option: define DDS_AMPL_RAMP_EN to ramp each channel's working
// amplitude toward AmplCntrl by RAMP_STEP per enabled cycle.
// There is no handshake: en gates every register except the LUT write port.
module dds_multich_amp #(
  parameter int NUM_CH    = 2,
  parameter int PHASE_W   = 32,
  parameter int ADDR_W    = 16,
  parameter int SAMPLE_W  = 16,
  parameter int AMPL_W    = 16,
  parameter int RAMP_STEP = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [PHASE_W-1:0]         FreqCntrl,
  input  logic [NUM_CH*PHASE_W-1:0]  PhaseCntrl,
  input  logic [NUM_CH*AMPL_W-1:0]   AmplCntrl,
  input  logic [1:0]                 DataPathSelect,
  input  logic [SAMPLE_W-1:0]        DirectValue,
  input  logic                       LUTWe,
  input  logic [ADDR_W-1:0]          LUTAddress,
  input  logic [SAMPLE_W-1:0]        LUTData,
  output logic [NUM_CH*SAMPLE_W-1:0] SampleOut,
  output logic                       SampleValid,
  output logic                       PhaseWrap
);

  localparam int PROD_W = SAMPLE_W + AMPL_W;
  localparam logic signed [PROD_W-1:0] RND_HALF = PROD_W'(2 ** (AMPL_W - 2));

  logic [SAMPLE_W-1:0] lut_mem [2**ADDR_W];

  logic [PHASE_W-1:0] acc;
  logic [PHASE_W:0]   acc_sum;
  logic [1:0]         vld_cnt;

  logic [ADDR_W-1:0]          addr_s1  [NUM_CH];
  logic signed [AMPL_W-1:0]   ampl_s1  [NUM_CH];
  logic signed [AMPL_W-1:0]   ampl_s2  [NUM_CH];
  logic signed [SAMPLE_W-1:0] lut_s2   [NUM_CH];
  logic signed [PROD_W-1:0]   prod_s3  [NUM_CH];
  logic signed [SAMPLE_W-1:0] byp_s3   [NUM_CH];
  logic [1:0]                 mode_s1, mode_s2, mode_s3;
  logic [SAMPLE_W-1:0]        direct_s1, direct_s2;

  logic [PHASE_W-1:0]         ph_sum   [NUM_CH];
  logic signed [AMPL_W-1:0]   ampl_src [NUM_CH];
  logic signed [PROD_W-1:0]   rnd_sum  [NUM_CH];
  logic signed [SAMPLE_W-1:0] out_nxt  [NUM_CH];

  // Carry out of the accumulator add drives PhaseWrap.
  assign acc_sum = {1'b0, acc} + {1'b0, FreqCntrl};

`ifdef DDS_AMPL_RAMP_EN
  localparam logic signed [AMPL_W:0] STEP_W = (AMPL_W+1)'(RAMP_STEP);

  logic signed [AMPL_W-1:0] ampl_work [NUM_CH];
  logic signed [AMPL_W-1:0] ampl_nxt  [NUM_CH];
  logic signed [AMPL_W:0]   ampl_diff [NUM_CH];

  // Next working amplitude: step toward target, land exactly when within one step.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ampl_diff[c] = {AmplCntrl[c*AMPL_W+AMPL_W-1], AmplCntrl[c*AMPL_W +: AMPL_W]}
                   - {ampl_work[c][AMPL_W-1], ampl_work[c]};
      ampl_nxt[c]  = $signed(AmplCntrl[c*AMPL_W +: AMPL_W]);
      if (ampl_diff[c] > STEP_W)
        ampl_nxt[c] = ampl_work[c] + AMPL_W'(RAMP_STEP);
      else if (ampl_diff[c] < -STEP_W)
        ampl_nxt[c] = ampl_work[c] - AMPL_W'(RAMP_STEP);
      ampl_src[c] = ampl_work[c];
    end
  end

  // Working amplitude register, cleared by reset and frozen while en is low.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst)     ampl_work[c] <= '0;
      else if (en) ampl_work[c] <= ampl_nxt[c];
    end
  end
`else
  // Amplitude goes straight from the control port into S1.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      ampl_src[c] = $signed(AmplCntrl[c*AMPL_W +: AMPL_W]);
  end
`endif

  // Channel phase and S4 round/saturate; only -1 x -1 can overflow positive.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ph_sum[c]  = acc + PhaseCntrl[c*PHASE_W +: PHASE_W];
      rnd_sum[c] = prod_s3[c] + RND_HALF;
      out_nxt[c] = byp_s3[c];
      if (mode_s3 == 2'd3) begin
        if (!rnd_sum[c][PROD_W-1] && rnd_sum[c][PROD_W-2])
          out_nxt[c] = {1'b0, {(SAMPLE_W-1){1'b1}}};
        else
          out_nxt[c] = rnd_sum[c][PROD_W-2 -: SAMPLE_W];
      end
    end
  end

  // LUT write port: never reset, independent of en.
  always_ff @(posedge clk) begin
    if (LUTWe) lut_mem[LUTAddress] <= LUTData;
  end

  // Accumulator, S1..S4 pipeline, valid and wrap flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      vld_cnt     <= '0;
      SampleValid <= 1'b0;
      PhaseWrap   <= 1'b0;
      SampleOut   <= '0;
      mode_s1     <= '0;
      mode_s2     <= '0;
      mode_s3     <= '0;
      direct_s1   <= '0;
      direct_s2   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        addr_s1[c] <= '0;
        ampl_s1[c] <= '0;
        ampl_s2[c] <= '0;
        lut_s2[c]  <= '0;
        prod_s3[c] <= '0;
        byp_s3[c]  <= '0;
      end
    end else if (en) begin
      acc       <= acc_sum[PHASE_W-1:0];
      PhaseWrap <= acc_sum[PHASE_W];
      if (vld_cnt != 2'd3) vld_cnt <= vld_cnt + 2'd1;
      else                 SampleValid <= 1'b1;
      mode_s1   <= DataPathSelect;
      mode_s2   <= mode_s1;
      mode_s3   <= mode_s2;
      direct_s1 <= DirectValue;
      direct_s2 <= direct_s1;
      for (int c = 0; c < NUM_CH; c++) begin
        addr_s1[c] <= ph_sum[c][PHASE_W-1 -: ADDR_W];
        ampl_s1[c] <= ampl_src[c];
        ampl_s2[c] <= ampl_s1[c];
        lut_s2[c]  <= lut_mem[addr_s1[c]];
        prod_s3[c] <= $signed(PROD_W'(lut_s2[c])) * $signed(PROD_W'(ampl_s2[c]));
        case (mode_s2)
          2'd1:    byp_s3[c] <= $signed(direct_s2);
          2'd2:    byp_s3[c] <= lut_s2[c];
          default: byp_s3[c] <= '0;
        endcase
        SampleOut[c*SAMPLE_W +: SAMPLE_W] <= out_nxt[c];
      end
    end else begin
      PhaseWrap <= 1'b0;
    end
  end

endmodule
